// File: rtl/rv32v_ex_mem_queue.sv
// Elastic FIFO between vector execute and vector memory stages.
// Carries per-lane results plus vector context; ex_ready depends only on registered occupancy.
module rv32v_ex_mem_queue #(
   parameter int LANES     = 2,
   parameter int DEPTH     = 2,
   parameter int OFFW      = 5,
   parameter int DROP_IDLE = 0
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     flush,
   input  logic                     ex_valid,
   output logic                     ex_ready,
   output logic                     mem_valid,
   input  logic                     mem_ready,
   input  logic                     ex_load,
   input  logic                     ex_store,
   input  logic [LANES-1:0]         ex_wen,
   input  logic [32*LANES-1:0]      ex_aluresult,
   input  logic [32*LANES-1:0]      ex_storedata,
   input  logic [OFFW*LANES-1:0]    ex_woffset,
   input  logic                     ex_config_type,
   input  logic                     ex_single_bit_write,
   input  logic [7:0]               ex_vtype,
   input  logic [1:0]               ex_eew,
   input  logic [4:0]               ex_vd,
   input  logic [31:0]              ex_vl,
   input  logic [31:0]              ex_vstart,
   output logic                     mem_load,
   output logic                     mem_store,
   output logic [LANES-1:0]         mem_wen,
   output logic [32*LANES-1:0]      mem_aluresult,
   output logic [32*LANES-1:0]      mem_storedata,
   output logic [OFFW*LANES-1:0]    mem_woffset,
   output logic                     mem_config_type,
   output logic                     mem_single_bit_write,
   output logic [7:0]               mem_vtype,
   output logic [1:0]               mem_eew,
   output logic [4:0]               mem_vd,
   output logic [31:0]              mem_vl,
   output logic [31:0]              mem_vstart,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                     dropped
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic DROP = (DROP_IDLE != 0);

   // Handshake: a packet moves on a side only in a cycle where its valid and
   // ready are both high at the rising edge; flush blocks both transfers.

   logic                   r_load_q    [DEPTH];
   logic                   r_store_q   [DEPTH];
   logic [LANES-1:0]       r_wen_q     [DEPTH];
   logic [32*LANES-1:0]    r_alu_q     [DEPTH];
   logic [32*LANES-1:0]    r_sdata_q   [DEPTH];
   logic [OFFW*LANES-1:0]  r_woff_q    [DEPTH];
   logic                   r_cfg_q     [DEPTH];
   logic                   r_sbw_q     [DEPTH];
   logic [7:0]             r_vtype_q   [DEPTH];
   logic [1:0]             r_eew_q     [DEPTH];
   logic [4:0]             r_vd_q      [DEPTH];
   logic [31:0]            r_vl_q      [DEPTH];
   logic [31:0]            r_vstart_q  [DEPTH];

   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic          r_dropped;

   logic w_ready;
   logic w_valid;
   logic w_accept;
   logic w_idle;
   logic w_enq;
   logic w_deq;

   assign w_ready  = !RST && (r_count < FULL_CNT);
   assign w_valid  = (r_count != '0);
   assign w_accept = ex_valid && w_ready && !flush;
   assign w_idle   = !ex_load && !ex_store && !ex_config_type && (ex_wen == '0);
   assign w_enq    = w_accept && !(DROP && w_idle);
   assign w_deq    = w_valid && mem_ready && !flush;

   always_ff @(posedge CLK) begin
      if (RST || flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_enq) r_tail <= r_tail + 1'b1;
         if (w_deq) r_head <= r_head + 1'b1;
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Flush and reset already gate w_accept, so no drop is reported for lost input.
   always_ff @(posedge CLK) begin
      if (RST) r_dropped <= 1'b0;
      else     r_dropped <= w_accept && DROP && w_idle;
   end

   // Payload storage needs no reset: unused entries are never shown on mem_*.
   always_ff @(posedge CLK) begin
      if (w_enq) begin
         r_load_q[r_tail]   <= ex_load;
         r_store_q[r_tail]  <= ex_store;
         r_wen_q[r_tail]    <= ex_wen;
         r_alu_q[r_tail]    <= ex_aluresult;
         r_sdata_q[r_tail]  <= ex_storedata;
         r_woff_q[r_tail]   <= ex_woffset;
         r_cfg_q[r_tail]    <= ex_config_type;
         r_sbw_q[r_tail]    <= ex_single_bit_write;
         r_vtype_q[r_tail]  <= ex_vtype;
         r_eew_q[r_tail]    <= ex_eew;
         r_vd_q[r_tail]     <= ex_vd;
         r_vl_q[r_tail]     <= ex_vl;
         r_vstart_q[r_tail] <= ex_vstart;
      end
   end

   assign ex_ready  = w_ready;
   assign mem_valid = w_valid;
   assign count     = r_count;
   assign dropped   = r_dropped;

   // Head packet is masked to zero whenever the buffer is empty.
   assign mem_load             = w_valid ? r_load_q[r_head]   : 1'b0;
   assign mem_store            = w_valid ? r_store_q[r_head]  : 1'b0;
   assign mem_wen              = w_valid ? r_wen_q[r_head]    : '0;
   assign mem_aluresult        = w_valid ? r_alu_q[r_head]    : '0;
   assign mem_storedata        = w_valid ? r_sdata_q[r_head]  : '0;
   assign mem_woffset          = w_valid ? r_woff_q[r_head]   : '0;
   assign mem_config_type      = w_valid ? r_cfg_q[r_head]    : 1'b0;
   assign mem_single_bit_write = w_valid ? r_sbw_q[r_head]    : 1'b0;
   assign mem_vtype            = w_valid ? r_vtype_q[r_head]  : '0;
   assign mem_eew              = w_valid ? r_eew_q[r_head]    : '0;
   assign mem_vd               = w_valid ? r_vd_q[r_head]     : '0;
   assign mem_vl               = w_valid ? r_vl_q[r_head]     : '0;
   assign mem_vstart           = w_valid ? r_vstart_q[r_head] : '0;

   a_count_range: assert property (@(posedge CLK) disable iff (RST) r_count <= FULL_CNT);
   a_no_enq_full: assert property (@(posedge CLK) disable iff (RST) (r_count == FULL_CNT) |-> !w_enq);

endmodule
